code_lock: RTL and testbench

//  Parametrised combination lock: N_BTN push-buttons enter a CODE_LEN-digit code; a correct code opens the lock for a timed window.

---
 rtl/lock_pkg.sv | 15 +
 rtl/btn_pulse.sv | 27 ++
 rtl/code_lock.sv | 161 ++++++++++++++++
 tb/tb_code_lock.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types for the code lock: FSM state encoding and digit-width helper.
package lock_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTRY   = 2'd1,
      OPEN    = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   function automatic int dw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_pulse.sv
// W-wide 2-FF synchroniser followed by a registered rising-edge detector.
module btn_pulse #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] pulse
);

   logic [W-1:0] s1, s2, prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= '0;
         s2    <= '0;
         prev  <= '0;
         pulse <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         prev  <= s2;
         pulse <= s2 & ~prev;
      end
   end

endmodule

// File: rtl/code_lock.sv
// Combination lock: digit entry FSM, fail counter, prescaled open/lockout timers.
module code_lock
   import lock_pkg::*;
#(
   parameter int N_BTN         = 4,
   parameter int CODE_LEN      = 4,
   parameter logic [CODE_LEN*$clog2(N_BTN)-1:0] CODE = 8'hE4,
   parameter int MAX_FAIL      = 3,
   parameter int TICK_DIV      = 100_000_000,
   parameter int UNLOCK_TICKS  = 5,
   parameter int LOCKOUT_TICKS = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_BTN-1:0]              btn,
   input  logic                          lock_req,
   output logic                          unlocked,
   output logic                          locked_out,
   output logic                          ok_pulse,
   output logic                          err_pulse,
   output logic [$clog2(CODE_LEN+1)-1:0] digit_cnt
);

   localparam int DW   = dw(N_BTN);
   localparam int CW   = $clog2(CODE_LEN+1);
   localparam int FW   = $clog2(MAX_FAIL+1);
   localparam int PW   = $clog2(TICK_DIV);
   localparam int TMAX = (UNLOCK_TICKS > LOCKOUT_TICKS) ?
                         UNLOCK_TICKS : LOCKOUT_TICKS;
   localparam int TW   = $clog2(TMAX+1);

   localparam logic [CW-1:0] D_LAST = CW'(CODE_LEN-1);
   localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAIL);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV-1);
   localparam logic [TW-1:0] U_LAST = TW'(UNLOCK_TICKS-1);
   localparam logic [TW-1:0] L_LAST = TW'(LOCKOUT_TICKS-1);

   state_t        state, nxt;
   logic [N_BTN-1:0] pbtn;
   logic          plock;
   logic [DW-1:0] dig, exp_dig;
   logic          press, bad, acc, tick;
   logic          mis_q, mis_n;
   logic [CW-1:0] dcnt_n;
   logic [FW-1:0] fail_cnt, fail_n, fail_inc;
   logic          ok_n, err_n;
   logic [PW-1:0] presc;
   logic [TW-1:0] tcnt;

   btn_pulse #(.W(N_BTN)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn),
      .pulse (pbtn)
   );

   btn_pulse #(.W(1)) u_lock (
      .clk   (clk),
      .rst   (rst),
      .raw   (lock_req),
      .pulse (plock)
   );

   // Encoded digit and the code digit expected at the current position
   always_comb begin
      dig     = '0;
      exp_dig = '0;
      for (int i = 0; i < N_BTN; i++)
         if (pbtn[i]) dig = DW'(i);
      for (int k = 0; k < CODE_LEN; k++)
         if (digit_cnt == CW'(k)) exp_dig = CODE[k*DW +: DW];
   end

   assign press    = |pbtn;
   assign bad      = !$onehot(pbtn) || (dig != exp_dig);
   assign acc      = bad || ((state == ENTRY) && mis_q);
   assign tick     = (presc == P_LAST);
   assign fail_inc = (fail_cnt == F_MAX) ? fail_cnt : fail_cnt + 1'b1;

   always_comb begin
      nxt    = state;
      dcnt_n = digit_cnt;
      mis_n  = mis_q;
      fail_n = fail_cnt;
      ok_n   = 1'b0;
      err_n  = 1'b0;
      unique case (state)
         IDLE, ENTRY: begin
            if (press) begin
               if (digit_cnt == D_LAST) begin
                  dcnt_n = '0;
                  mis_n  = 1'b0;
                  if (!acc) begin
                     nxt    = OPEN;
                     ok_n   = 1'b1;
                     fail_n = '0;
                  end else begin
                     err_n  = 1'b1;
                     fail_n = fail_inc;
                     nxt    = (fail_inc == F_MAX) ? LOCKOUT : IDLE;
                  end
               end else begin
                  nxt    = ENTRY;
                  dcnt_n = digit_cnt + 1'b1;
                  mis_n  = acc;
               end
            end
         end
         OPEN: begin
            if (plock || (tick && tcnt == U_LAST))
               nxt = IDLE;
         end
         LOCKOUT: begin
            if (tick && tcnt == L_LAST) begin
               nxt    = IDLE;
               fail_n = '0;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         digit_cnt <= '0;
         mis_q     <= 1'b0;
         fail_cnt  <= '0;
         ok_pulse  <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= nxt;
         digit_cnt <= dcnt_n;
         mis_q     <= mis_n;
         fail_cnt  <= fail_n;
         ok_pulse  <= ok_n;
         err_pulse <= err_n;
      end
   end

   // Timers restart on every state change so windows are exact
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         tcnt  <= '0;
      end else if (nxt != state) begin
         presc <= '0;
         tcnt  <= '0;
      end else if (tick) begin
         presc <= '0;
         if (state == OPEN || state == LOCKOUT)
            tcnt <= tcnt + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign unlocked   = (state == OPEN);
   assign locked_out = (state == LOCKOUT);

endmodule

// File: tb/tb_code_lock.sv
// Directed self-checking bench for code_lock with short timing parameters.
module tb_code_lock;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btn = '0;
   logic       lock_req = 1'b0;
   logic       unlocked, locked_out, ok_pulse, err_pulse;
   logic [2:0] digit_cnt;

   int n_run  = 0;
   int n_fail = 0;
   int ok_cnt = 0, err_cnt = 0, unl_cyc = 0, lo_cyc = 0;
   int ok0, err0, unl0, lo0;

   always #5 clk = ~clk;

   code_lock #(
      .TICK_DIV      (4),
      .UNLOCK_TICKS  (3),
      .LOCKOUT_TICKS (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .lock_req   (lock_req),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .ok_pulse   (ok_pulse),
      .err_pulse  (err_pulse),
      .digit_cnt  (digit_cnt)
   );

   always @(negedge clk) begin
      if (rst) begin
         if (ok_pulse)   ok_cnt++;
         if (err_pulse)  err_cnt++;
         if (unlocked)   unl_cyc++;
         if (locked_out) lo_cyc++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic snap();
      ok0  = ok_cnt;
      err0 = err_cnt;
      unl0 = unl_cyc;
      lo0  = lo_cyc;
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      btn      = '0;
      lock_req = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic press(input logic [3:0] b, input int hold, input int post);
      @(posedge clk);
      #1 btn = b;
      repeat (hold) @(posedge clk);
      #1 btn = '0;
      repeat (post) @(posedge clk);
   endtask

   task automatic pulse_lock(input int hold, input int post);
      @(posedge clk);
      #1 lock_req = 1'b1;
      repeat (hold) @(posedge clk);
      #1 lock_req = 1'b0;
      repeat (post) @(posedge clk);
   endtask

   task automatic enter(input logic [15:0] seq);
      for (int i = 0; i < 4; i++) press(seq[i*4 +: 4], 5, 4);
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      chk("rst_unlocked", unlocked, 0);
      chk("rst_locked", locked_out, 0);
      chk("rst_ok", ok_pulse, 0);
      chk("rst_err", err_pulse, 0);
      chk("rst_dcnt", digit_cnt, 0);

      // correct code opens for 12 cycles
      snap();
      enter(16'h8421);
      @(negedge clk);
      chk("t1_open", unlocked, 1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t1_ok_cnt", ok_cnt - ok0, 1);
      chk("t1_err_cnt", err_cnt - err0, 0);
      chk("t1_open_cyc", unl_cyc - unl0, 12);
      chk("t1_closed", unlocked, 0);

      // wrong last digit; digit_cnt progression
      do_reset();
      snap();
      press(4'h1, 5, 4); @(negedge clk); chk("t2_dcnt1", digit_cnt, 1);
      press(4'h2, 5, 4); @(negedge clk); chk("t2_dcnt2", digit_cnt, 2);
      press(4'h4, 5, 4); @(negedge clk); chk("t2_dcnt3", digit_cnt, 3);
      press(4'h4, 5, 4); @(negedge clk); chk("t2_dcnt0", digit_cnt, 0);
      chk("t2_err_cnt", err_cnt - err0, 1);
      chk("t2_ok_cnt", ok_cnt - ok0, 0);
      chk("t2_open_cyc", unl_cyc - unl0, 0);

      // three failures -> 8-cycle lockout, presses ignored meanwhile
      do_reset();
      snap();
      enter(16'h1111);
      enter(16'h1111);
      press(4'h1, 5, 4);
      press(4'h1, 5, 4);
      press(4'h1, 5, 4);
      press(4'h1, 1, 0);
      press(4'h1, 1, 0);
      repeat (14) @(posedge clk);
      @(negedge clk);
      chk("t3_err_cnt", err_cnt - err0, 3);
      chk("t3_lo_cyc", lo_cyc - lo0, 8);
      chk("t3_dcnt", digit_cnt, 0);
      chk("t3_lo_end", locked_out, 0);
      enter(16'h8421);
      @(negedge clk);
      chk("t3_open", unlocked, 1);

      // multi-bit first digit is a mismatch; long hold counts once
      do_reset();
      snap();
      enter(16'h8423);
      @(negedge clk);
      chk("t4_err_cnt", err_cnt - err0, 1);
      chk("t4_unlocked", unlocked, 0);
      press(4'h1, 20, 4);
      @(negedge clk);
      chk("t4_hold_dcnt", digit_cnt, 1);

      // lock_req at cycle 2 of OPEN, then ignored during ENTRY
      do_reset();
      snap();
      press(4'h1, 5, 4);
      press(4'h2, 5, 4);
      press(4'h4, 5, 4);
      press(4'h8, 1, 0);
      pulse_lock(1, 10);
      @(negedge clk);
      chk("t5_open_cyc", unl_cyc - unl0, 2);
      chk("t5_relocked", unlocked, 0);
      snap();
      press(4'h1, 5, 4);
      pulse_lock(5, 4);
      @(negedge clk);
      chk("t5_entry_dcnt", digit_cnt, 1);
      press(4'h2, 5, 4);
      press(4'h4, 5, 4);
      press(4'h8, 5, 4);
      @(negedge clk);
      chk("t5_ok_cnt", ok_cnt - ok0, 1);
      chk("t5_open", unlocked, 1);

      // async reset mid-ENTRY and mid-OPEN
      do_reset();
      snap();
      press(4'h1, 5, 4);
      press(4'h2, 5, 4);
      @(negedge clk);
      chk("t6_dcnt2", digit_cnt, 2);
      #2 rst = 1'b0;
      #1 chk("t6_rst_dcnt", digit_cnt, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      snap();
      press(4'h4, 5, 4);
      press(4'h8, 5, 4);
      @(negedge clk);
      chk("t6_resume_dcnt", digit_cnt, 2);
      press(4'h1, 5, 4);
      press(4'h2, 5, 4);
      @(negedge clk);
      chk("t6_err_cnt", err_cnt - err0, 1);
      chk("t6_ok_cnt", ok_cnt - ok0, 0);
      enter(16'h8421);
      @(negedge clk);
      chk("t6_open", unlocked, 1);
      #2 rst = 1'b0;
      #1 chk("t6_rst_unlocked", unlocked, 0);
      chk("t6_rst_locked", locked_out, 0);
      chk("t6_rst_err", err_pulse, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
